dmem_wb_responder: RTL and testbench
====================================

Name: dmem_wb_responder

Overview:
Wishbone classic data-memory responder for the core's MEM stage. It services the load/store unit's bus requests and returns read data with a single-cycle ack. That ack and data are the mem-ack and MEM-stage data used by the forwarding logic. Internal word-organised RAM with byte-lane writes, a configurable wait-state count, and an error response for misaligned or out-of-range accesses.

Parameters:
MEM_WORDS, 1024, number of 32-bit words in the RAM (power of two)
BASE_ADDR, 32'h0000_1000, byte address of word 0
WAIT_STATES, 1, cycles inserted between request capture and ack (0..15)

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  asynchronous, active-high reset
wb_cyc_i  in  1  bus cycle active
wb_stb_i  in  1  strobe, request valid
wb_we_i  in  1  1 = store, 0 = load
wb_adr_i  in  32  byte address
wb_dat_i  in  32  store data
wb_sel_i  in  4  byte-lane enables, bit n = byte n (little-endian)
wb_dat_o  out  32  load data, valid while wb_ack_o = 1
wb_ack_o  out  1  one-cycle normal termination
wb_err_o  out  1  one-cycle error termination

Behaviour:
- Reset (async, rst_i=1): state IDLE, wait counter 0, wb_ack_o=0, wb_err_o=0, wb_dat_o=0. RAM contents are not reset. Reset mid-transfer aborts with no write and no ack.
- FSM states: IDLE, WAIT, RESP.
- IDLE: on a cycle with cyc&stb=1, capture adr, we, dat_i and sel. Load the counter with WAIT_STATES. Go to WAIT, or go to RESP when WAIT_STATES=0.
- WAIT: decrement the counter each cycle. When the counter reaches 1, go to RESP on the next edge. If wb_cyc_i=0 in any WAIT cycle, return to IDLE with no write, no ack and no err.
- Transition into RESP (single edge):
  - Decode: word index = (adr - BASE_ADDR) >> 2.
  - Fault when adr[1:0] != 0, or adr < BASE_ADDR, or index >= MEM_WORDS.
  - Fault: wb_err_o=1, wb_ack_o=0, no RAM write, wb_dat_o unchanged.
  - OK store: for each lane with sel bit set, write that byte of dat_i. Set wb_ack_o=1. wb_dat_o unchanged. sel=4'b0000 acks with no change.
  - OK load: wb_dat_o = full RAM word regardless of sel. Set wb_ack_o=1.
- RESP: lasts exactly one cycle. ack/err clear on the next edge. Always return to IDLE. A request is never captured in RESP.
- Latency: request sampled at edge T produces ack/err high during the cycle after edge T+1+WAIT_STATES.
- Back-to-back: minimum one IDLE cycle between transfers. If the master holds stb after ack, the next request is captured in IDLE.
- wb_dat_o holds the last load value between loads. Stores and errors never alter it.
- Read-after-write to the same word in consecutive transfers returns the new data. No bypass needed, because the write completes before the next capture.
- ack and err are never high together. Neither is ever high for two consecutive cycles.
- Inputs other than cyc are ignored after capture. Changing adr/dat mid-WAIT has no effect.

Test Plan:
- WAIT_STATES=1:
  - Store adr 0x1000, dat 0xDEADBEEF, sel 4'hF, sampled at edge T -> ack high one cycle after edge T+2.
  - Then load 0x1000 -> wb_dat_o=0xDEADBEEF with ack, err=0 throughout.
- Byte lanes:
  - Preload 0x1004 = 0x11223344.
  - Store dat 0xAABBCCDD with sel 4'b0101.
  - Load 0x1004 -> 0x11BB33DD.
  - A store with sel 4'b0000 acks and leaves the word unchanged.
- Errors:
  - Load 0x1002 (misaligned) -> err one cycle, ack=0, wb_dat_o unchanged.
  - Store 0x0FFC (below base) -> err, no RAM change.
  - Store to 0x1000 + 4*MEM_WORDS -> err, no RAM change.
- Abort:
  - Store 0x1008 dat 0x12345678, drop cyc during WAIT -> no ack, no err.
  - A subsequent load of 0x1008 returns the prior value.
- WAIT_STATES=0:
  - Stb held high across two loads -> acks one cycle after edges T+1 and T+3, separated by exactly one low cycle.
- Async reset:
  - Assert rst_i mid-WAIT of a store -> ack/err/dat_o go to 0 immediately, without a clock edge.
  - After release, loading that address shows the store did not occur.

Source files
------------

// File: rtl/dmem_wb_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | dmem_wb_responder: Wishbone classic data-memory slave for the MEM stage.    |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
module dmem_wb_responder #(
   parameter int          MEM_WORDS   = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
   parameter int          WAIT_STATES = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   input  logic [3:0]  wb_sel_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        wb_err_o
);

   localparam int c_IDX_W = $clog2(MEM_WORDS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [31:0]   adr_q, adr_d;
   logic [31:0]   dat_q, dat_d;
   logic [3:0]    sel_q, sel_d;
   logic          we_q, we_d;
   logic          ack_q, ack_d;
   logic          err_q, err_d;
   logic [31:0]   rdat_q, rdat_d;

   logic                w_req;
   logic [29:0]         w_word;
   logic [c_IDX_W-1:0]  w_idx;
   logic                w_fault;
   logic                w_wr_en;
   logic [31:0]         w_rword;

   assign w_req   = wb_cyc_i & wb_stb_i;
   // BASE_ADDR is word aligned, so the word offset needs only the upper address bits.
   assign w_word  = adr_q[31:2] - BASE_ADDR[31:2];
   assign w_idx   = w_word[c_IDX_W-1:0];
   assign w_fault = (adr_q[1:0] != 2'b00) | (adr_q < BASE_ADDR) | (w_word >= 30'(MEM_WORDS));
   assign w_wr_en = (state_q == S_RESP) & we_q & ~w_fault;

   // One byte-wide array per lane so each lane maps onto its own write enable.
   for (genvar g = 0; g < 4; g++) begin : g_lane
      logic [7:0] mem_q [MEM_WORDS];

      always_ff @(posedge clk_i) begin
         if (w_wr_en && sel_q[g]) begin
            mem_q[w_idx] <= dat_q[8*g +: 8];
         end
      end

      assign w_rword[8*g +: 8] = mem_q[w_idx];
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      sel_d   = sel_q;
      we_d    = we_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      rdat_d  = rdat_q;

      case (state_q)
         S_IDLE: begin
            if (w_req) begin
               adr_d   = wb_adr_i;
               dat_d   = wb_dat_i;
               sel_d   = wb_sel_i;
               we_d    = wb_we_i;
               cnt_d   = 4'(WAIT_STATES);
               state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            if (!wb_cyc_i) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q <= 4'd1) begin
                  state_d = S_RESP;
               end
            end
         end
         S_RESP: begin
            // Termination is registered here, so ack/err show up in the following IDLE cycle.
            state_d = S_IDLE;
            if (w_fault) begin
               err_d = 1'b1;
            end else begin
               ack_d = 1'b1;
               if (!we_q) begin
                  rdat_d = w_rword;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         adr_q   <= 32'd0;
         dat_q   <= 32'd0;
         sel_q   <= 4'd0;
         we_q    <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rdat_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         sel_q   <= sel_d;
         we_q    <= we_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         rdat_q  <= rdat_d;
      end
   end

   assign wb_dat_o = rdat_q;
   assign wb_ack_o = ack_q;
   assign wb_err_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_wb_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_dmem_wb_responder: scoreboard bench for two responders (0 and 1 waits).  |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
module tb_dmem_wb_responder;

   localparam int          MEM_WORDS = 1024;
   localparam logic [31:0] BASE      = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cyc  [2];
   logic        stb  [2];
   logic        we   [2];
   logic [31:0] adr  [2];
   logic [31:0] wdat [2];
   logic [3:0]  sel  [2];
   logic [31:0] rdat [2];
   logic        ack  [2];
   logic        err  [2];

   always #5 clk = ~clk;

   dmem_wb_responder #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE), .WAIT_STATES(0)) dut0 (
      .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we[0]),
      .wb_adr_i(adr[0]), .wb_dat_i(wdat[0]), .wb_sel_i(sel[0]),
      .wb_dat_o(rdat[0]), .wb_ack_o(ack[0]), .wb_err_o(err[0]));

   dmem_wb_responder #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE), .WAIT_STATES(1)) dut1 (
      .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we[1]),
      .wb_adr_i(adr[1]), .wb_dat_i(wdat[1]), .wb_sel_i(sel[1]),
      .wb_dat_o(rdat[1]), .wb_ack_o(ack[1]), .wb_err_o(err[1]));

   typedef struct {
      bit          is_err;
      logic [31:0] dat;
      longint      cyc;
   } exp_t;

   exp_t        q0[$];
   exp_t        q1[$];
   int          checks = 0;
   int          errors = 0;
   longint      cyc_cnt = 0;
   logic [31:0] mdl [longint];
   logic [31:0] last_ld [2];
   int          resp_cnt [2];
   bit          prev_resp [2];

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   function automatic int ws(input int id);
      return (id == 0) ? 0 : 1;
   endfunction

   // Reference: byte-addressed view of the memory window, one word map per instance.
   task automatic model(input int id, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output exp_t e);
      longint      key;
      logic [31:0] word;
      bit          bad;
      bad = (a % 4 != 0) || (longint'(a) < longint'(BASE)) ||
            (longint'(a) >= longint'(BASE) + 4 * MEM_WORDS);
      e.cyc = 0;
      if (bad) begin
         e.is_err = 1'b1;
         e.dat    = last_ld[id];
         return;
      end
      key = longint'(id) * 65536 + (longint'(a) - longint'(BASE)) / 4;
      e.is_err = 1'b0;
      word = mdl.exists(key) ? mdl[key] : 32'd0;
      if (w) begin
         for (int b = 0; b < 4; b++) begin
            if (s[b]) word[8*b +: 8] = d[8*b +: 8];
         end
         mdl[key] = word;
         e.dat    = last_ld[id];
      end else begin
         last_ld[id] = word;
         e.dat       = word;
      end
   endtask

   task automatic monitor_step(input int id);
      exp_t e;
      int   qs;
      if (ack[id] || err[id]) begin
         resp_cnt[id]++;
         chk($sformatf("dut%0d ack_err_exclusive", id), {31'd0, ack[id] & err[id]}, 32'd0);
         chk($sformatf("dut%0d no_consecutive_resp", id), {31'd0, prev_resp[id]}, 32'd0);
         qs = (id == 0) ? q0.size() : q1.size();
         if (qs == 0) begin
            checks++;
            errors++;
            $display("FAIL dut%0d unexpected_resp: got ack=%b err=%b, expected no response",
                     id, ack[id], err[id]);
         end else begin
            e = (id == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("dut%0d err_flag", id), {31'd0, err[id]}, {31'd0, e.is_err});
            chk($sformatf("dut%0d ack_flag", id), {31'd0, ack[id]}, {31'd0, !e.is_err});
            chk($sformatf("dut%0d dat_o", id), rdat[id], e.dat);
            chk($sformatf("dut%0d resp_cycle", id), 32'(cyc_cnt), 32'(e.cyc));
         end
      end
      prev_resp[id] = ack[id] | err[id];
   endtask

   always @(negedge clk) begin
      if (rst) begin
         prev_resp[0] = 1'b0;
         prev_resp[1] = 1'b0;
      end else begin
         monitor_step(0);
         monitor_step(1);
      end
   end

   task automatic push(input int id, input exp_t e);
      if (id == 0) q0.push_back(e);
      else         q1.push_back(e);
   endtask

   task automatic xfer(input int id, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
      exp_t e;
      bit   got;
      @(posedge clk); #1;
      cyc[id] = 1'b1; stb[id] = 1'b1; we[id] = w; adr[id] = a; wdat[id] = d; sel[id] = s;
      @(posedge clk); #1;
      model(id, w, a, d, s, e);
      e.cyc = cyc_cnt + 1 + ws(id);
      push(id, e);
      // Request is captured; scramble the bus to show it is ignored.
      stb[id] = 1'b0; we[id] = 1'($urandom); adr[id] = $urandom; wdat[id] = $urandom;
      sel[id] = 4'($urandom);
      got = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (ack[id] || err[id]) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL dut%0d timeout: got no ack/err within 40 cycles, expected a response at %h",
                  id, a);
      end
      cyc[id] = 1'b0;
   endtask

   function automatic logic [31:0] pool_addr(input int k);
      return BASE + 32'(4 * ((k < 16) ? k : (1004 + k)));
   endfunction

   function automatic logic [31:0] bad_addr();
      case ($urandom_range(0, 3))
         0:       return pool_addr($urandom_range(0, 19)) + 32'($urandom_range(1, 3));
         1:       return 32'($urandom_range(0, 32'h0FFF));
         2:       return BASE + 32'(4 * MEM_WORDS) + 32'(4 * $urandom_range(0, 1000));
         default: return 32'hF000_0000 | ($urandom & 32'h0FFF_FFFC);
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t        e;
      longint      t;
      int          n;
      logic [31:0] a;
      for (int i = 0; i < 2; i++) begin
         cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0; adr[i] = '0; wdat[i] = '0; sel[i] = '0;
         last_ld[i] = '0; resp_cnt[i] = 0; prev_resp[i] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("dut%0d reset_ack", i), {31'd0, ack[i]}, 32'd0);
         chk($sformatf("dut%0d reset_err", i), {31'd0, err[i]}, 32'd0);
         chk($sformatf("dut%0d reset_dat", i), rdat[i], 32'd0);
      end
      @(negedge clk);
      rst = 1'b0;

      for (int id = 0; id < 2; id++) begin
         for (int k = 0; k < 20; k++) xfer(id, 1'b1, pool_addr(k), $urandom, 4'hF);

         xfer(id, 1'b1, 32'h1000, 32'hDEADBEEF, 4'hF);
         xfer(id, 1'b0, 32'h1000, 32'h0, 4'hF);
         chk($sformatf("dut%0d load_deadbeef", id), rdat[id], 32'hDEADBEEF);

         xfer(id, 1'b1, 32'h1004, 32'h11223344, 4'hF);
         xfer(id, 1'b1, 32'h1004, 32'hAABBCCDD, 4'b0101);
         xfer(id, 1'b0, 32'h1004, 32'h0, 4'b0001);
         chk($sformatf("dut%0d byte_lane_merge", id), rdat[id], 32'h11BB33DD);
         xfer(id, 1'b1, 32'h1004, 32'hFFFFFFFF, 4'b0000);
         xfer(id, 1'b0, 32'h1004, 32'h0, 4'hF);
         chk($sformatf("dut%0d sel_zero_store", id), rdat[id], 32'h11BB33DD);

         xfer(id, 1'b0, 32'h1002, 32'h0, 4'hF);
         chk($sformatf("dut%0d misaligned_keeps_dat", id), rdat[id], 32'h11BB33DD);
         xfer(id, 1'b1, 32'h0FFC, 32'h0BAD0BAD, 4'hF);
         xfer(id, 1'b1, BASE + 32'(4 * MEM_WORDS), 32'h0BAD0BAD, 4'hF);
         xfer(id, 1'b0, BASE + 32'(4 * (MEM_WORDS - 1)), 32'h0, 4'hF);
         xfer(id, 1'b0, 32'h1000, 32'h0, 4'hF);
      end

      // Zero wait states, strobe held: second request is taken in the IDLE cycle after RESP.
      @(posedge clk); #1;
      cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = pool_addr(2); sel[0] = 4'hF;
      @(posedge clk); #1;
      t = cyc_cnt;
      model(0, 1'b0, pool_addr(2), 32'h0, 4'hF, e);
      e.cyc = t + 1;
      push(0, e);
      adr[0] = pool_addr(3);
      @(posedge clk);
      @(posedge clk); #1;
      model(0, 1'b0, pool_addr(3), 32'h0, 4'hF, e);
      e.cyc = t + 3;
      push(0, e);
      stb[0] = 1'b0;
      repeat (3) @(negedge clk);
      cyc[0] = 1'b0;

      // Abort by dropping cyc during the wait state.
      xfer(1, 1'b1, 32'h1008, 32'hCAFEF00D, 4'hF);
      @(posedge clk); #1;
      cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h1008; wdat[1] = 32'h12345678;
      sel[1] = 4'hF;
      @(posedge clk); #1;
      n = resp_cnt[1];
      stb[1] = 1'b0; cyc[1] = 1'b0;
      repeat (5) @(negedge clk);
      chk("dut1 abort_no_response", 32'(resp_cnt[1]), 32'(n));
      xfer(1, 1'b0, 32'h1008, 32'h0, 4'hF);
      chk("dut1 abort_no_write", rdat[1], 32'hCAFEF00D);

      // Asynchronous reset in the middle of a store's wait state.
      xfer(1, 1'b1, 32'h100C, 32'h0BADCAFE, 4'hF);
      xfer(1, 1'b0, 32'h100C, 32'h0, 4'hF);
      @(posedge clk); #1;
      cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h100C; wdat[1] = 32'h55555555;
      sel[1] = 4'hF;
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("dut1 async_rst_ack", {31'd0, ack[1]}, 32'd0);
      chk("dut1 async_rst_err", {31'd0, err[1]}, 32'd0);
      chk("dut1 async_rst_dat", rdat[1], 32'd0);
      cyc[1] = 1'b0; stb[1] = 1'b0;
      last_ld[0] = '0;
      last_ld[1] = '0;
      #3;
      rst = 1'b0;
      xfer(1, 1'b0, 32'h100C, 32'h0, 4'hF);
      chk("dut1 reset_abort_no_write", rdat[1], 32'h0BADCAFE);

      // Randomised traffic against the reference model.
      for (int id = 0; id < 2; id++) begin
         for (int k = 0; k < 80; k++) begin
            n = $urandom_range(0, 99);
            if (n < 40) begin
               xfer(id, 1'b0, pool_addr($urandom_range(0, 19)), $urandom, 4'($urandom));
            end else if (n < 75) begin
               xfer(id, 1'b1, pool_addr($urandom_range(0, 19)), $urandom, 4'($urandom));
            end else begin
               a = bad_addr();
               xfer(id, 1'($urandom), a, $urandom, 4'($urandom));
            end
         end
      end

      repeat (5) @(negedge clk);
      chk("dut0 scoreboard_drained", 32'(q0.size()), 32'd0);
      chk("dut1 scoreboard_drained", 32'(q1.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
